// File: rtl/vjtag_pkg.sv
// vjtag_pkg: shared types and constants for the virtual-JTAG scan master.
//   state_t           : scan FSM states (IDLE, UIR, CDR, SDR, UDR, DONE)
//   *_WIDTH_DEFAULT   : default DR / IR scan lengths (debug slave sr/jdo width)
//   IR_*              : IR codes as decoded by the CPU debug slave
package vjtag_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UIR,
        CDR,
        SDR,
        UDR,
        DONE
    } state_t;

    localparam int DR_WIDTH_DEFAULT = 38;
    localparam int IR_WIDTH_DEFAULT = 2;

    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_BREAK     = 2'd1;  // decoded by the slave, never issued by this master
    localparam logic [1:0] IR_BREAKRD   = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

endpackage

// File: rtl/vjtag_tck_gen.sv
// vjtag_tck_gen: divided TCK generator.
//   clk, reset : system clock, async active-high reset
//   run        : enables toggling; when low, tck is parked low and the divider restarts
//   tck        : registered TCK, toggles every TCK_DIV clk cycles while run
//   rise, fall : single-cycle strobes, high in the cycle whose closing clk edge
//                registers tck 0->1 (rise) or 1->0 (fall)
module vjtag_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tck,
    output logic rise,
    output logic fall
);

    localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    logic [CW-1:0] div_cnt;
    logic          wrap;

    assign wrap = run && (div_cnt == CW'(TCK_DIV - 1));
    assign rise = wrap && !tck;
    assign fall = wrap && tck;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            tck     <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            tck     <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            tck     <= ~tck;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vjtag_scan_master.sv
// vjtag_scan_master: initiator end of the 2-bit-IR virtual-JTAG debug channel.
// Accepts one {IR, DR} command, runs UIR -> CDR -> SDR -> UDR with a divided
// TCK and returns the TDO word captured during SDR.
//   cmd_*      : command port (valid/ready), cmd_data shifted out LSB first
//   rsp_*      : response port (valid/ready), rsp_data LSB = first bit shifted
//   vji_*      : virtual JTAG signal set consumed by the debug slave
// Optional build macro VJTAG_IR_CACHE_EN: remember the last IR written and skip
// the UIR period when a command repeats it.
module vjtag_scan_master
    import vjtag_pkg::*;
#(
    parameter int DR_WIDTH = DR_WIDTH_DEFAULT,
    parameter int IR_WIDTH = IR_WIDTH_DEFAULT,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    input  logic [IR_WIDTH-1:0] vji_ir_out,
    output logic                vji_rti,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr
);

    localparam int CNT_W  = $clog2(DR_WIDTH + 1);
    localparam int TAIL_W = $clog2(TCK_DIV + 2);

    state_t              state;
    logic [DR_WIDTH-1:0] sr;
    logic [DR_WIDTH-1:0] sr_next;
    logic [DR_WIDTH-1:0] cap;
    logic [CNT_W-1:0]    bit_cnt;
    logic                tail;
    logic [TAIL_W-1:0]   tail_cnt;
    logic                run;
    logic                rise;
    logic                fall;
    logic                accept;
    logic                skip_uir;

    // After the UDR fall TCK is parked, so the divider must stop during the tail.
    assign run     = (state inside {UIR, CDR, SDR, UDR}) && !tail;
    assign accept  = cmd_valid && cmd_ready && (state == IDLE);
    assign sr_next = sr >> 1;

    vjtag_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .tck   (vji_tck),
        .rise  (rise),
        .fall  (fall)
    );

`ifdef VJTAG_IR_CACHE_EN
    logic                cache_vld;
    logic [IR_WIDTH-1:0] cache_ir;

    assign skip_uir = cache_vld && (cmd_ir == cache_ir);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cache_vld <= 1'b0;
            cache_ir  <= '0;
        end else if (accept && !skip_uir) begin
            cache_vld <= 1'b1;
            cache_ir  <= cmd_ir;
        end
    end
`else
    assign skip_uir = 1'b0;
`endif

    // State flags and tdi only move at accept (TCK already low) or on a fall
    // strobe, so every TCK rise sees settled levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_ir_out <= '0;
            vji_tdi    <= 1'b0;
            vji_ir_in  <= '0;
            vji_rti    <= 1'b1;
            vji_uir    <= 1'b0;
            vji_cdr    <= 1'b0;
            vji_sdr    <= 1'b0;
            vji_udr    <= 1'b0;
            sr         <= '0;
            cap        <= '0;
            bit_cnt    <= '0;
            tail       <= 1'b0;
            tail_cnt   <= '0;
        end else begin
            // Registered from the state, so ready shows up one cycle after IDLE entry.
            cmd_ready <= (state == IDLE) && !accept;

            case (state)
                IDLE: begin
                    if (accept) begin
                        sr       <= cmd_data;
                        bit_cnt  <= '0;
                        tail     <= 1'b0;
                        tail_cnt <= '0;
                        vji_rti  <= 1'b0;
                        if (skip_uir) begin
                            vji_cdr <= 1'b1;
                            state   <= CDR;
                        end else begin
                            vji_ir_in <= cmd_ir;
                            vji_uir   <= 1'b1;
                            state     <= UIR;
                        end
                    end
                end

                UIR: begin
                    if (rise)
                        rsp_ir_out <= vji_ir_out;
                    if (fall) begin
                        vji_uir <= 1'b0;
                        vji_cdr <= 1'b1;
                        state   <= CDR;
                    end
                end

                CDR: begin
                    if (fall) begin
                        vji_cdr <= 1'b0;
                        vji_sdr <= 1'b1;
                        vji_tdi <= sr[0];
                        state   <= SDR;
                    end
                end

                SDR: begin
                    if (rise)
                        cap[bit_cnt] <= vji_tdo;
                    if (fall) begin
                        sr      <= sr_next;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(DR_WIDTH - 1)) begin
                            vji_sdr <= 1'b0;
                            vji_tdi <= 1'b0;
                            vji_udr <= 1'b1;
                            state   <= UDR;
                        end else begin
                            vji_tdi <= sr_next[0];
                        end
                    end
                end

                UDR: begin
                    // One TCK period of udr, then a parked-low tail of
                    // TCK_DIV+1 cycles before the response is presented.
                    if (!tail) begin
                        if (fall) begin
                            vji_udr  <= 1'b0;
                            vji_rti  <= 1'b1;
                            tail     <= 1'b1;
                            tail_cnt <= '0;
                        end
                    end else if (tail_cnt == TAIL_W'(TCK_DIV)) begin
                        tail      <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_data  <= cap;
                        state     <= DONE;
                    end else begin
                        tail_cnt <= tail_cnt + 1'b1;
                    end
                end

                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
